// File: rtl/fabric_spi_transmitter.sv
// SPI mode-0 controller: streams 32-bit words out MSB first with frame-wide chip select,
// returning the word clocked back on MISO as a one-cycle pulse.
module fabric_spi_transmitter #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic        last_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  output logic        sclk_o,
  output logic        cs_no,
  output logic        mosi_o,
  input  logic        miso_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } state_t;

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [5:0]  bit_cnt_r;
  logic [31:0] tx_shift_r;
  logic [30:0] rx_shift_r;
  logic        cur_last_r;
  logic [31:0] hold_data_r;
  logic        hold_last_r;
  logic        hold_valid_r;
  logic        load_s;
  logic        sample_s;

  assign ready_o = !hold_valid_r;

  // Decide when the shifter takes the held word: frame start, after a stall, or chained mid-frame.
  always_comb begin
    load_s = 1'b0;
    if (hold_valid_r) begin
      case (state_r)
        ST_IDLE, ST_WAIT: load_s = 1'b1;
        ST_HIGH:          load_s = (cnt_r == 16'd0) && (bit_cnt_r == 6'd31) && !cur_last_r;
        ST_LOW:           load_s = (bit_cnt_r == 6'd32) && !cur_last_r;
        default:          load_s = 1'b0;
      endcase
    end else begin
      load_s = 1'b0;
    end
  end

  // MISO is captured on the clk edge that drives sclk_o from 0 to 1.
  assign sample_s = (state_r == ST_HIGH) && !sclk_o;

  // Frame sequencer, shifters, holding register and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 16'd0;
      bit_cnt_r    <= 6'd0;
      tx_shift_r   <= 32'd0;
      rx_shift_r   <= 31'd0;
      cur_last_r   <= 1'b0;
      hold_data_r  <= 32'd0;
      hold_last_r  <= 1'b0;
      hold_valid_r <= 1'b0;
      sclk_o       <= 1'b0;
      cs_no        <= 1'b1;
      mosi_o       <= 1'b0;
      busy_o       <= 1'b0;
      rx_valid_o   <= 1'b0;
      rx_data_o    <= 32'd0;
    end else begin
      // Pins follow the state one cycle later, so mosi and sclk stay phase-aligned.
      sclk_o     <= (state_r == ST_HIGH);
      cs_no      <= (state_r == ST_IDLE) || (state_r == ST_GAP);
      busy_o     <= (state_r != ST_IDLE);
      mosi_o     <= ((state_r == ST_IDLE) || (state_r == ST_GAP)) ? 1'b0 : tx_shift_r[31];
      rx_valid_o <= 1'b0;

      if (sample_s) begin
        rx_shift_r <= {rx_shift_r[29:0], miso_i};
        if (bit_cnt_r == 6'd31) begin
          rx_data_o  <= {rx_shift_r, miso_i};
          rx_valid_o <= 1'b1;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (hold_valid_r) begin
            state_r <= ST_SETUP;
            cnt_r   <= 16'(CS_SETUP - 1);
          end
        end
        ST_SETUP: begin
          if (cnt_r == 16'd0) begin
            state_r <= ST_HIGH;
            cnt_r   <= 16'(CLK_DIV - 1);
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_HIGH: begin
          if (cnt_r == 16'd0) begin
            state_r    <= ST_LOW;
            cnt_r      <= 16'(CLK_DIV - 1);
            bit_cnt_r  <= bit_cnt_r + 6'd1;
            tx_shift_r <= {tx_shift_r[30:0], 1'b0};
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_LOW: begin
          if (cnt_r == 16'd0) begin
            if (bit_cnt_r != 6'd32) begin
              state_r <= ST_HIGH;
              cnt_r   <= 16'(CLK_DIV - 1);
            end else if (cur_last_r) begin
              state_r <= ST_HOLD;
              cnt_r   <= 16'(CS_HOLD - 1);
            end else if (hold_valid_r) begin
              state_r <= ST_HIGH;
              cnt_r   <= 16'(CLK_DIV - 1);
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_WAIT: begin
          if (hold_valid_r) begin
            state_r <= ST_LOW;
            cnt_r   <= 16'(CLK_DIV - 1);
          end
        end
        ST_HOLD: begin
          if (cnt_r == 16'd0) begin
            state_r <= ST_GAP;
            cnt_r   <= 16'(CS_IDLE - 1);
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_GAP: begin
          if (cnt_r == 16'd0) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // A load overrides the shift/bit-count updates made above on the same edge.
      if (load_s) begin
        tx_shift_r   <= hold_data_r;
        cur_last_r   <= hold_last_r;
        bit_cnt_r    <= 6'd0;
        hold_valid_r <= 1'b0;
      end

      if (valid_i && !hold_valid_r) begin
        hold_data_r  <= data_i;
        hold_last_r  <= last_i;
        hold_valid_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fabric_spi_transmitter.sv
// Directed bench for fabric_spi_transmitter: a MOSI/MISO monitor-responder plus
// scoreboard queues filled when words are offered and drained as the DUT shifts them.
module tb_fabric_spi_transmitter;
  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_i = 32'd0;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic        miso_i = 1'b0;
  logic        ready_o, busy_o, rx_valid_o, sclk_o, cs_no, mosi_o;
  logic [31:0] rx_data_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nbits = 0;
  int exp_cs_fall = -1;
  int resume_at = -1;
  logic [31:0] tx_exp[$];
  logic [31:0] rx_exp[$];
  logic [31:0] resp_q[$];

  fabric_spi_transmitter #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .busy_o(busy_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .sclk_o(sclk_o), .cs_no(cs_no), .mosi_o(mosi_o), .miso_i(miso_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one word; mode 1 expects a fresh frame start, mode 2 a resume from a stall.
  task automatic send(input logic [31:0] d, input logic l, input logic [31:0] r, input int mode);
    int n;
    int t;
    n = 0;
    while (!ready_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait_bound", 32'(n < 5000), 32'd1);
    tx_exp.push_back(d);
    rx_exp.push_back(r);
    resp_q.push_back(r);
    data_i = d;
    last_i = l;
    valid_i = 1'b1;
    t = cyc + 1;
    @(posedge clk);
    if (mode == 1) exp_cs_fall = t + 2;
    if (mode == 2) resume_at = t + 2 + CLK_DIV;
    @(negedge clk);
    valid_i = 1'b0;
    check("ready_low_after_accept", 32'(ready_o), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cs_no && !busy_o && tx_exp.size() == 0 && rx_exp.size() == 0) && n < 5000);
    check("idle_wait_bound", 32'(n < 5000), 32'd1);
  endtask

  // Monitor: checks SCLK/CS timing, rebuilds MOSI words, checks RX pulses, and drives MISO.
  initial begin : monitor
    logic prev_sclk, prev_cs, prev_rx, have_cs_rise, first_rise, rword_v;
    int last_rise, last_fall, last_cs_rise, rbit;
    logic [31:0] mon_word, rword;
    prev_sclk = 1'b0; prev_cs = 1'b1; prev_rx = 1'b0; have_cs_rise = 1'b0;
    first_rise = 1'b1; rword_v = 1'b0; last_rise = 0; last_fall = 0; last_cs_rise = 0;
    rbit = 0; mon_word = 32'd0; rword = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sclk = 1'b0; prev_cs = 1'b1; prev_rx = 1'b0; have_cs_rise = 1'b0;
        first_rise = 1'b1; rword_v = 1'b0; rbit = 0; nbits = 0;
        miso_i = 1'b0;
      end else begin
        if (prev_cs && !cs_no) begin
          if (exp_cs_fall >= 0) begin
            check("cs_fall_latency", 32'(cyc), 32'(exp_cs_fall));
            exp_cs_fall = -1;
          end
          if (have_cs_rise) check("cs_idle_gap", 32'(cyc - last_cs_rise >= CS_IDLE), 32'd1);
          check("busy_in_frame", 32'(busy_o), 32'd1);
          first_rise = 1'b1;
          nbits = 0;
          rbit = 0;
        end
        if (!prev_cs && cs_no) begin
          check("cs_hold_time", 32'(cyc - last_fall), 32'(CLK_DIV + CS_HOLD));
          check("frame_word_aligned", 32'(nbits), 32'd0);
          last_cs_rise = cyc;
          have_cs_rise = 1'b1;
        end
        if (!prev_sclk && sclk_o) begin
          check("sclk_rise_cs_low", 32'(cs_no), 32'd0);
          if (!first_rise) begin
            if (resume_at >= 0 && nbits == 0) begin
              check("resume_full_low", 32'(cyc), 32'(resume_at));
              resume_at = -1;
            end else begin
              check("sclk_period", 32'(cyc - last_rise), 32'(2 * CLK_DIV));
            end
          end
          first_rise = 1'b0;
          last_rise = cyc;
          mon_word = {mon_word[30:0], mosi_o};
          nbits++;
          if (nbits == 32) begin
            nbits = 0;
            if (tx_exp.size() != 0) begin
              check("tx_word", mon_word, tx_exp.pop_front());
            end else begin
              total++; bad++;
              $error("FAIL tx_word observed=%h expected=none", mon_word);
            end
          end
        end
        if (prev_sclk && !sclk_o) begin
          check("sclk_high_width", 32'(cyc - last_rise), 32'(CLK_DIV));
          last_fall = cyc;
          rbit++;
          if (rbit == 32) begin
            rbit = 0;
            rword_v = 1'b0;
          end
        end
        if (rx_valid_o) begin
          check("rx_pulse_on_32nd_rise", 32'({sclk_o && !prev_sclk, nbits == 0}), 32'd3);
          check("rx_pulse_single", 32'(prev_rx), 32'd0);
          if (rx_exp.size() != 0) begin
            check("rx_word", rx_data_o, rx_exp.pop_front());
          end else begin
            total++; bad++;
            $error("FAIL rx_word observed=%h expected=none", rx_data_o);
          end
        end
        if (!cs_no && !rword_v && resp_q.size() != 0) begin
          rword = resp_q.pop_front();
          rword_v = 1'b1;
        end
        miso_i = rword_v ? rword[5'(31 - rbit)] : 1'b0;
        prev_sclk = sclk_o;
        prev_cs = cs_no;
        prev_rx = rx_valid_o;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_cs_no", 32'(cs_no), 32'd1);
    check("reset_sclk", 32'(sclk_o), 32'd0);
    check("reset_mosi", 32'(mosi_o), 32'd0);
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_rx_valid", 32'(rx_valid_o), 32'd0);
    check("reset_rx_data", rx_data_o, 32'd0);

    // Single-word frame.
    send(32'hA5A5_0001, 1'b1, 32'h1234_5678, 1);
    wait_idle();

    // Three words streamed in one frame.
    send(32'hFFFF_FFFF, 1'b0, 32'hCAFE_F00D, 1);
    send(32'h0000_0000, 1'b0, 32'h0F0F_0F0F, 0);
    send(32'hDEAD_BEEF, 1'b1, 32'h8000_0001, 0);
    wait_idle();

    // Mid-frame stall of 50 cycles between words.
    send(32'h1357_9BDF, 1'b0, 32'h2468_ACE0, 1);
    n = 0;
    while (rx_exp.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("stall_word1_bound", 32'(n < 5000), 32'd1);
    repeat (2 * CLK_DIV + 2) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      check("stall_sclk_low", 32'(sclk_o), 32'd0);
      check("stall_cs_low", 32'(cs_no), 32'd0);
      @(negedge clk);
    end
    send(32'hB00B_1E55, 1'b1, 32'h7E57_0042, 2);
    wait_idle();

    // Two single-word frames back to back.
    send(32'h0F1E_2D3C, 1'b1, 32'h5A5A_A5A5, 1);
    send(32'hC3D2_E1F0, 1'b1, 32'h0000_FFFF, 0);
    wait_idle();

    // Asynchronous reset at bit 10, then a clean frame.
    send(32'h1122_3344, 1'b1, 32'h5566_7788, 1);
    n = 0;
    while (nbits != 10 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reset_point_bound", 32'(n < 5000), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_cs_no", 32'(cs_no), 32'd1);
    check("midreset_sclk", 32'(sclk_o), 32'd0);
    check("midreset_busy", 32'(busy_o), 32'd0);
    check("midreset_ready", 32'(ready_o), 32'd1);
    check("midreset_rx_data", rx_data_o, 32'd0);
    tx_exp.delete();
    rx_exp.delete();
    resp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h9ABC_DEF0, 1'b1, 32'h0FED_CBA9, 1);
    wait_idle();

    check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_exp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
